// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch front-end: reset vector,
// datapath widths and the buffered {pc, instr} entry layout.
package instr_prefetch_buffer_pkg;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_prefetch_buffer_fifo.sv
// Small synchronous FIFO with occupancy count; flush beats push and pop.
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: issues word reads to a 1-cycle RAM,
// buffers {pc, instr} pairs and hands them to fetch; redirects flush and restart.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ram_ena,
  output logic [3:0]  ram_wea,
  output logic [31:0] ram_w_data,
  output logic [31:0] ram_addr,
  input  logic [31:0] ram_r_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [CW-1:0] count;
  logic [SW-1:0] credits_used;
  logic [31:0]   fetch_pc, inflight_pc;
  logic          inflight;
  logic          push, pop;
  fetch_entry_t  push_entry, head;

  // Outstanding read counts against capacity so a response always has a slot.
  assign credits_used = SW'(count) + SW'(inflight);
  assign ram_ena      = !rst && (redirect_valid || (credits_used < SW'(DEPTH)));
  assign ram_addr     = redirect_valid ? word_align(redirect_pc) : fetch_pc;
  assign ram_wea      = 4'b0000;
  assign ram_w_data   = 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      if (ram_ena) fetch_pc <= ram_addr + 32'd4;
      inflight    <= ram_ena;
      inflight_pc <= ram_addr;
    end
  end

  // A redirect in the response cycle makes the returning word stale.
  assign push       = inflight && !redirect_valid;
  assign pop        = out_ready && !redirect_valid && !rst;
  assign push_entry = '{pc: inflight_pc, instr: ram_r_data};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign out_valid = !rst && (count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed + randomized bench for instr_prefetch_buffer against a stream-level model.
module tb_instr_prefetch_buffer;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hBFC00000;
  localparam logic [31:0] KEY    = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst, ram_ena, redirect_valid, out_valid, out_ready;
  logic [3:0]  ram_wea;
  logic [31:0] ram_w_data, ram_addr, ram_r_data, redirect_pc, out_pc, out_instr;

  int          n_cmp = 0, n_err = 0, n_pops = 0;
  int          pend, fresh;        // words owed to the core since last flush; issued last cycle
  logic [31:0] nip, exp_pc;        // next PC to issue; next PC the core should see

  always #5 clk = ~clk;

  // RAM model: 1-cycle latency, contents are address ^ KEY.
  initial ram_r_data = 32'h0;
  always_ff @(posedge clk) if (ram_ena) ram_r_data <= ram_addr ^ KEY;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_w_data(ram_w_data),
    .ram_addr(ram_addr), .ram_r_data(ram_r_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model, land 1 time unit after the edge.
  task automatic cycle();
    logic [31:0] ea;
    logic        ee, ev, pop;
    @(negedge clk);
    ea  = redirect_valid ? {redirect_pc[31:2], 2'b00} : nip;
    ee  = !rst && (redirect_valid || pend < DEPTH);
    ev  = !rst && (pend - fresh) != 0;
    pop = ev && out_ready && !redirect_valid;
    chk("ram_ena", 32'(ram_ena), 32'(ee));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ee) chk("ram_addr", ram_addr, ea);
    if (pop) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_instr", out_instr, exp_pc ^ KEY);
      n_pops++;
    end
    if (rst) begin
      pend = 0; fresh = 0; nip = RST_PC; exp_pc = RST_PC;
    end else if (redirect_valid) begin
      pend = 1; fresh = 1; nip = ea + 32'd4; exp_pc = ea;
    end else begin
      pend  = pend + int'(ee) - int'(pop);
      fresh = int'(ee);
      if (ee)  nip    = nip + 32'd4;
      if (pop) exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    pend = 0; fresh = 0; nip = RST_PC; exp_pc = RST_PC;
    @(posedge clk); #1;
    run(3);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("ram_wea", 32'(ram_wea), 32'h0);
    chk("ram_w_data", ram_w_data, 32'h0);

    // Streaming from the reset vector.
    rst = 1'b0; out_ready = 1'b1;
    run(2);
    chk("first_valid", 32'(out_valid), 32'h1);
    chk("first_pc", out_pc, RST_PC);
    run(12);

    // Fill with core stalled, then drain.
    rst = 1'b1; run(1);
    rst = 1'b0; out_ready = 1'b0;
    run(10);
    chk("full_stall_ena", 32'(ram_ena), 32'h0);
    out_ready = 1'b1;
    chk("drain_head_pc", out_pc, RST_PC);
    run(10);

    // Redirect to an unaligned PC with 3 entries buffered.
    rst = 1'b1; run(1);
    rst = 1'b0; out_ready = 1'b0;
    run(4);
    redirect_valid = 1'b1; redirect_pc = 32'h00400123;
    run(1);
    redirect_valid = 1'b0; out_ready = 1'b1;
    run(1);
    chk("redir_valid", 32'(out_valid), 32'h1);
    chk("redir_pc", out_pc, 32'h00400120);
    run(8);

    // Back-to-back redirects: only the second stream survives.
    redirect_valid = 1'b1; redirect_pc = 32'h00001000; run(1);
    redirect_pc = 32'h00002000; run(1);
    redirect_valid = 1'b0;
    run(1);
    chk("b2b_pc", out_pc, 32'h00002000);
    run(8);

    // Random back-pressure with occasional redirects.
    for (int i = 0; i < 1000; i++) begin
      out_ready      = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 49) == 0);
      redirect_pc    = $urandom;
      run(1);
    end
    redirect_valid = 1'b0;
    chk("random_pops_nonzero", 32'(n_pops > 500), 32'h1);

    // Reset mid-stream with the buffer full.
    out_ready = 1'b0;
    run(8);
    rst = 1'b1; run(1);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    run(2);
    chk("midrst_restart_pc", out_pc, RST_PC);
    run(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
